// File: rtl/sample_serializer_pkg.sv
// Shared constants for the sample serializer and its downstream receiver.
// Word length and FIFO depth live here so both ends agree on framing.
package sample_serializer_pkg;

    localparam int unsigned SAMPLE_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH   = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_serializer_if.sv
// Parallel sample valid/ready handshake into the serializer.
interface sample_serializer_if
    import sample_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_WIDTH
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/sample_serializer_fifo.sv
// Synchronous DEPTH x WIDTH sample FIFO; push when full and pop when empty are ignored.
module sample_fifo
    import sample_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                    clk16,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        head,
    output logic [clog2(DEPTH):0]   level,
    output logic                    full,
    output logic                    empty
);
    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk16 or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk16) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sample_serializer.sv
// Buffers parallel samples and emits them as a gapless MSB-first bit stream.
// On underrun the last emitted word is repeated so word alignment never slips.
module sample_serializer
    import sample_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                    clk16,
    input  logic                    rst,
    input  logic                    bit_en,
    sample_serializer_if.slave      in_if,
    output logic                    data_out,
    output logic                    frame_start,
    output logic                    underrun,
    output logic [clog2(DEPTH):0]   level
);
    localparam int unsigned CNT_W = clog2(WIDTH);

    logic [CNT_W-1:0] bitcnt, bitcnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] head;
    logic             data_n, frame_start_n, underrun_n;
    logic             pop, push, full, empty;

    assign in_if.din_ready = !full;
    assign push            = in_if.din_valid && !full;

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk16 (clk16),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_if.din),
        .head  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk16 or negedge rst) begin
        if (!rst) begin
            bitcnt      <= '0;
            shreg       <= '0;
            hold        <= '0;
            data_out    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            bitcnt      <= bitcnt_n;
            shreg       <= shreg_n;
            hold        <= hold_n;
            data_out    <= data_n;
            frame_start <= frame_start_n;
            underrun    <= underrun_n;
        end
    end

    // Frame boundary loads a new word (FIFO head or held word); otherwise shift.
    always_comb begin
        bitcnt_n      = bitcnt;
        shreg_n       = shreg;
        hold_n        = hold;
        data_n        = data_out;
        frame_start_n = 1'b0;
        underrun_n    = 1'b0;
        pop           = 1'b0;
        word          = hold;
        if (bit_en) begin
            if (bitcnt == '0) begin
                if (!empty) begin
                    word = head;
                    pop  = 1'b1;
                end else begin
                    underrun_n = 1'b1;
                end
                data_n        = word[WIDTH-1];
                shreg_n       = {word[WIDTH-2:0], 1'b0};
                hold_n        = word;
                frame_start_n = 1'b1;
            end else begin
                data_n  = shreg[WIDTH-1];
                shreg_n = {shreg[WIDTH-2:0], 1'b0};
            end
            bitcnt_n = (bitcnt == CNT_W'(WIDTH - 1)) ? '0 : bitcnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer: handshake, framing, underrun, reset and throughput.
module tb_sample_serializer;
    import sample_serializer_pkg::*;

    logic       clk16 = 1'b0;
    logic       rst;
    logic       bit_en;
    logic       data_out;
    logic       frame_start;
    logic       underrun;
    logic [2:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    sample_serializer_if #(.WIDTH(8)) bus ();

    sample_serializer dut (
        .clk16       (clk16),
        .rst         (rst),
        .bit_en      (bit_en),
        .in_if       (bus),
        .data_out    (data_out),
        .frame_start (frame_start),
        .underrun    (underrun),
        .level       (level)
    );

    always #5 clk16 = ~clk16;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b0; bit_en = 1'b1; bus.din_valid = 1'b0; bus.din = 8'h00;
        repeat (3) @(negedge clk16);
        n_checks++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_out got=%b exp=0", data_out); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_checks++; if (bus.din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready got=%b exp=1", bus.din_ready); end
    endtask

    // Empty FIFO: zeros out, frame_start/underrun at cycles 1, 9, 17.
    task automatic test_idle_underrun();
        logic [2:0] exp;
        rst = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk16);
            exp = {1'b0, (k % 8) == 1, (k % 8) == 1};
            n_checks++; if ({data_out, frame_start, underrun} !== exp) begin n_fail++; $display("FAIL idle_c%0d got=%b exp=%b", k, {data_out, frame_start, underrun}, exp); end
            n_checks++; if ({level, bus.din_ready} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL idle_lvl_c%0d got=%0d/%b exp=0/1", k, level, bus.din_ready); end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        logic [2:0] exp;
        w = 8'hA5;
        bit_en = 1'b0; bus.din = w; bus.din_valid = 1'b1;
        @(negedge clk16);
        bus.din_valid = 1'b0;
        n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level got=%0d exp=1", level); end
        bit_en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk16);
                exp = {w[7-b], b == 0, (b == 0) && (f == 1)};
                n_checks++; if ({data_out, frame_start, underrun} !== exp) begin n_fail++; $display("FAIL single_f%0d_b%0d got=%b exp=%b", f, b, {data_out, frame_start, underrun}, exp); end
            end
        end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL single_level_end got=%0d exp=0", level); end
    endtask

    task automatic test_fill_full();
        logic [7:0] w;
        logic [7:0] exp_w;
        logic [1:0] flags;
        bit_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.din = 8'(i); bus.din_valid = 1'b1;
            @(negedge clk16);
            n_checks++; if (level !== 3'((i < 4) ? i : 4)) begin n_fail++; $display("FAIL fill_level_%0d got=%0d exp=%0d", i, level, (i < 4) ? i : 4); end
            n_checks++; if (bus.din_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready_%0d got=%b exp=%b", i, bus.din_ready, i < 4); end
        end
        @(negedge clk16);
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level_hold got=%0d exp=4", level); end
        bus.din_valid = 1'b0;
        bit_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            w = 8'h00; flags = 2'b00;
            for (int b = 0; b < 8; b++) begin
                @(negedge clk16);
                w = {w[6:0], data_out};
                if (b == 0) flags = {frame_start, underrun};
            end
            exp_w = 8'((f < 4) ? f + 1 : 4);
            n_checks++; if (w !== exp_w) begin n_fail++; $display("FAIL drain_word_%0d got=%h exp=%h", f, w, exp_w); end
            n_checks++; if (flags !== {1'b1, f == 4}) begin n_fail++; $display("FAIL drain_flags_%0d got=%b exp=%b", f, flags, {1'b1, f == 4}); end
            if (f == 0) begin
                n_checks++; if ({level, bus.din_ready} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL drain_level got=%0d/%b exp=3/1", level, bus.din_ready); end
            end
        end
    endtask

    // bit_en every 4th cycle: each bit held 4 cycles, frame every 32.
    task automatic test_slow_bit_en();
        logic [7:0] w0, w1, cur;
        logic [2:0] exp;
        int e;
        w0 = 8'h3C; w1 = 8'hC3;
        bit_en = 1'b0;
        bus.din = w0; bus.din_valid = 1'b1;
        @(negedge clk16);
        bus.din = w1;
        @(negedge clk16);
        bus.din_valid = 1'b0;
        for (int c = 0; c < 64; c++) begin
            bit_en = (c % 4) == 0;
            @(negedge clk16);
            e = c / 4;
            cur = (e < 8) ? w0 : w1;
            exp = {cur[7 - (e % 8)], (c % 32) == 0, 1'b0};
            n_checks++; if ({data_out, frame_start, underrun} !== exp) begin n_fail++; $display("FAIL slow_c%0d got=%b exp=%b", c, {data_out, frame_start, underrun}, exp); end
        end
        bit_en = 1'b0;
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL slow_level got=%0d exp=0", level); end
    endtask

    // One push per frame at full bit rate: never underruns, level stays 0..1.
    task automatic test_stream();
        logic [7:0] s [100];
        logic [7:0] w;
        for (int i = 0; i < 100; i++) s[i] = 8'(i * 37 + 11);
        bit_en = 1'b0; bus.din = s[0]; bus.din_valid = 1'b1;
        @(negedge clk16);
        w = 8'h00;
        for (int c = 0; c < 800; c++) begin
            bit_en = 1'b1;
            if ((c % 8) == 0 && (c / 8 + 1) < 100) begin
                bus.din = s[c / 8 + 1]; bus.din_valid = 1'b1;
            end else begin
                bus.din_valid = 1'b0;
            end
            @(negedge clk16);
            w = {w[6:0], data_out};
            if ((c % 8) == 0) begin
                n_checks++; if ({frame_start, underrun} !== 2'b10) begin n_fail++; $display("FAIL stream_flags_f%0d got=%b exp=10", c / 8, {frame_start, underrun}); end
            end
            if ((c % 8) == 7) begin
                n_checks++; if (w !== s[c / 8]) begin n_fail++; $display("FAIL stream_word_%0d got=%h exp=%h", c / 8, w, s[c / 8]); end
            end
            n_checks++; if (level > 3'd1) begin n_fail++; $display("FAIL stream_level_c%0d got=%0d exp<=1", c, level); end
        end
        bus.din_valid = 1'b0;
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL stream_level_end got=%0d exp=0", level); end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] exp;
        bit_en = 1'b0; bus.din = 8'hFF; bus.din_valid = 1'b1;
        @(negedge clk16);
        bus.din_valid = 1'b0; bit_en = 1'b1;
        repeat (4) @(negedge clk16);
        n_checks++; if (data_out !== 1'b1) begin n_fail++; $display("FAIL midrst_before got=%b exp=1", data_out); end
        rst = 1'b0;
        #1;
        n_checks++; if ({data_out, frame_start, underrun, level} !== 6'd0) begin n_fail++; $display("FAIL midrst_async got=%b/%b/%b/%0d exp=0/0/0/0", data_out, frame_start, underrun, level); end
        @(negedge clk16);
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk16);
            exp = {1'b0, (k % 8) == 1, (k % 8) == 1};
            n_checks++; if ({data_out, frame_start, underrun} !== exp) begin n_fail++; $display("FAIL midrst_c%0d got=%b exp=%b", k, {data_out, frame_start, underrun}, exp); end
        end
    endtask

    // Bench-side receiver: align on frame_start, collect 8 bits, duty = word << 2.
    task automatic test_loopback();
        logic [7:0] w;
        logic [9:0] duty;
        bit found;
        bit_en = 1'b0; bus.din = 8'h80; bus.din_valid = 1'b1;
        @(negedge clk16);
        bus.din_valid = 1'b0; bit_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk16);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL loop_frame_start got=%b exp=1 (timeout)", found); end
        w = {7'd0, data_out};
        repeat (7) begin
            @(negedge clk16);
            w = {w[6:0], data_out};
        end
        duty = {w, 2'b00};
        n_checks++; if (duty !== 10'h200) begin n_fail++; $display("FAIL loop_duty got=%h exp=200", duty); end
    endtask

    initial begin
        test_reset();
        test_idle_underrun();
        test_single_word();
        test_fill_full();
        test_slow_bit_en();
        test_stream();
        test_reset_mid_frame();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
